// File: rtl/sample_tick_gen_if.sv
// SPS-change handshake and tick outputs of sample_tick_gen, bundled for port connection.
// master drives the request side; slave is the tick generator itself.
interface sample_tick_gen_if #(
    parameter int SPS_W = 8
);
    logic             sps_req;
    logic [SPS_W-1:0] sps_val;
    logic             sps_ack;
    logic             sample_en;
    logic             symbol_en;
    logic [SPS_W-1:0] sample_idx;
    logic             clk_lost;
    logic [1:0]       fsm_state;

    modport master (
        output sps_req, sps_val,
        input  sps_ack, sample_en, symbol_en, sample_idx, clk_lost, fsm_state
    );

    modport slave (
        input  sps_req, sps_val,
        output sps_ack, sample_en, symbol_en, sample_idx, clk_lost, fsm_state
    );
endinterface

// File: rtl/sample_tick_gen.sv
// Converts div_clk rising edges into sample/symbol enables in the clk32M768 domain,
// with boundary-aligned run-time SPS changes and a stalled-div_clk watchdog.
module sample_tick_gen #(
    parameter int SPS_W       = 8,
    parameter int SPS_DEFAULT = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic              clk32M768,
    input  logic              rst_n,
    input  logic              div_clk,
    sample_tick_gen_if.slave  bus
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             div_clk_d;
    logic             rise;
    logic [SPS_W-1:0] sps_cur, sps_pend, sample_idx, idx_nxt, last_idx;
    logic [WD_W-1:0]  wdog, wdog_nxt;
    logic             sample_en, symbol_en, sps_ack, clk_lost;
    logic             apply_bound, apply_lost;

    assign rise     = div_clk & ~div_clk_d;
    assign last_idx = sps_cur - SPS_W'(1);
    assign idx_nxt  = (sample_idx >= last_idx) ? '0 : sample_idx + SPS_W'(1);
    assign wdog_nxt = rise ? '0 : ((wdog == WD_W'(TIMEOUT)) ? wdog : wdog + WD_W'(1));

    // 4-phase handshake: sps_req rises and holds; sps_ack rises once the new SPS is
    // live and holds until sps_req drops; sps_ack then drops and IDLE accepts again.
    always_comb begin
        state_nxt   = state;
        apply_bound = 1'b0;
        apply_lost  = 1'b0;
        case (state)
            IDLE: if (bus.sps_req) state_nxt = PEND;
            PEND: begin
                if (rise && (idx_nxt == '0)) begin
                    apply_bound = 1'b1;
                    state_nxt   = ACK;
                end else if (clk_lost) begin
                    apply_lost = 1'b1;
                    state_nxt  = ACK;
                end
            end
            ACK:     if (!bus.sps_req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk32M768 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // div_clk_d resets high so a div_clk already high at release is not an edge.
    always_ff @(posedge clk32M768 or negedge rst_n) begin
        if (!rst_n) begin
            div_clk_d  <= 1'b1;
            sample_en  <= 1'b0;
            symbol_en  <= 1'b0;
            sps_ack    <= 1'b0;
            clk_lost   <= 1'b0;
            wdog       <= '0;
            sps_cur    <= SPS_W'(SPS_DEFAULT);
            sps_pend   <= SPS_W'(SPS_DEFAULT);
            sample_idx <= SPS_W'(SPS_DEFAULT - 1);
        end else begin
            div_clk_d <= div_clk;
            wdog      <= wdog_nxt;
            sample_en <= rise;
            symbol_en <= rise && (idx_nxt == '0);
            sps_ack   <= (state_nxt == ACK);
            if (rise)
                clk_lost <= 1'b0;
            else if (wdog_nxt == WD_W'(TIMEOUT))
                clk_lost <= 1'b1;
            // While stalled, idx parks on the last sample so recovery starts a symbol.
            if (rise)
                sample_idx <= idx_nxt;
            else if (apply_lost)
                sample_idx <= sps_pend - SPS_W'(1);
            else if (clk_lost)
                sample_idx <= last_idx;
            if ((state == IDLE) && bus.sps_req)
                sps_pend <= (bus.sps_val == '0) ? SPS_W'(1) : bus.sps_val;
            if (apply_bound || apply_lost)
                sps_cur <= sps_pend;
        end
    end

    assign bus.sps_ack    = sps_ack;
    assign bus.sample_en  = sample_en;
    assign bus.symbol_en  = symbol_en;
    assign bus.sample_idx = sample_idx;
    assign bus.clk_lost   = clk_lost;
    assign bus.fsm_state  = state;
endmodule

// File: tb/tb_sample_tick_gen.sv
// Directed bench for sample_tick_gen: div_clk from a 4-bit counter bit 3 (period 16),
// SPS_DEFAULT=4, TIMEOUT=64.
module tb_sample_tick_gen;
    logic       clk;
    logic       rst_n;
    logic       div_clk;
    logic       div_run;
    logic [3:0] cnt;
    int         total;
    int         passed;
    int         failed;
    int         stray;
    int         n;
    int         en_cnt;
    logic [3:0] d;

    sample_tick_gen_if #(.SPS_W(8)) bus ();

    sample_tick_gen #(
        .SPS_W       (8),
        .SPS_DEFAULT (4),
        .TIMEOUT     (64)
    ) dut (
        .clk32M768 (clk),
        .rst_n     (rst_n),
        .div_clk   (div_clk),
        .bus       (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1ns after the edge, then div_clk advances for the next edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (bus.symbol_en && !bus.sample_en) stray++;
        if (div_run) begin
            cnt     = cnt + 4'd1;
            div_clk = cnt[3];
        end
    endtask

    task automatic wait_sample(output int k);
        k = 0;
        do begin
            cyc();
            k++;
        end while (!bus.sample_en && (k < 200));
        check("pulse_seen", {31'd0, bus.sample_en}, 32'd1);
    endtask

    task automatic wait_lost(output int k, output int ens);
        k   = 0;
        ens = 0;
        do begin
            cyc();
            k++;
            if (bus.sample_en || bus.symbol_en) ens++;
        end while (!bus.clk_lost && (k < 200));
    endtask

    initial begin
        total  = 0;
        passed = 0;
        failed = 0;
        stray  = 0;
        rst_n  = 1'b0;
        cnt    = 4'd8;
        div_clk = 1'b1;
        div_run = 1'b1;
        bus.sps_req = 1'b0;
        bus.sps_val = 8'd0;

        // 1: reset state, release while div_clk is high
        repeat (3) cyc();
        check("rst_sample_en", {31'd0, bus.sample_en}, 32'd0);
        check("rst_symbol_en", {31'd0, bus.symbol_en}, 32'd0);
        check("rst_sps_ack", {31'd0, bus.sps_ack}, 32'd0);
        check("rst_clk_lost", {31'd0, bus.clk_lost}, 32'd0);
        check("rst_idx", {24'd0, bus.sample_idx}, 32'd3);
        check("rst_state", {30'd0, bus.fsm_state}, 32'd0);
        check("rel_div_high", {31'd0, div_clk}, 32'd1);
        rst_n = 1'b1;
        d = 4'd8 - cnt;
        wait_sample(n);
        check("first_pulse_wait", n, int'(d) + 1);
        check("first_idx", {24'd0, bus.sample_idx}, 32'd0);
        check("first_sym", {31'd0, bus.symbol_en}, 32'd1);

        // 2: free run, SPS=4
        for (int i = 1; i <= 20; i++) begin
            wait_sample(n);
            check("run_spacing", n, 16);
            check("run_idx", {24'd0, bus.sample_idx}, i % 4);
            check("run_sym", {31'd0, bus.symbol_en}, ((i % 4) == 0) ? 32'd1 : 32'd0);
        end
        check("run_no_stray_sym", stray, 0);

        // 3: SPS change to 8 requested during the idx 1 pulse
        wait_sample(n);
        check("t3_idx1", {24'd0, bus.sample_idx}, 32'd1);
        bus.sps_req = 1'b1;
        bus.sps_val = 8'd8;
        wait_sample(n);
        check("t3_idx2", {24'd0, bus.sample_idx}, 32'd2);
        check("t3_ack_idx2", {31'd0, bus.sps_ack}, 32'd0);
        wait_sample(n);
        check("t3_idx3", {24'd0, bus.sample_idx}, 32'd3);
        check("t3_ack_idx3", {31'd0, bus.sps_ack}, 32'd0);
        wait_sample(n);
        check("t3_bound_idx", {24'd0, bus.sample_idx}, 32'd0);
        check("t3_bound_sym", {31'd0, bus.symbol_en}, 32'd1);
        check("t3_bound_ack", {31'd0, bus.sps_ack}, 32'd1);
        for (int i = 1; i <= 8; i++) begin
            wait_sample(n);
            check("t3_idx8", {24'd0, bus.sample_idx}, i % 8);
            check("t3_sym8", {31'd0, bus.symbol_en}, ((i % 8) == 0) ? 32'd1 : 32'd0);
        end
        check("t3_ack_held", {31'd0, bus.sps_ack}, 32'd1);
        bus.sps_req = 1'b0;
        cyc();
        check("t3_ack_drop", {31'd0, bus.sps_ack}, 32'd0);

        // 4: stall div_clk, then recover
        wait_sample(n);
        div_run = 1'b0;
        div_clk = 1'b0;
        wait_lost(n, en_cnt);
        check("t4_lost_latency", n, 64);
        check("t4_no_enables", en_cnt, 0);
        cyc();
        check("t4_idx_held", {24'd0, bus.sample_idx}, 32'd7);
        cnt = 4'd7;
        div_run = 1'b1;
        wait_sample(n);
        check("t4_restart_wait", n, 2);
        check("t4_lost_clear", {31'd0, bus.clk_lost}, 32'd0);
        check("t4_restart_idx", {24'd0, bus.sample_idx}, 32'd0);
        check("t4_restart_sym", {31'd0, bus.symbol_en}, 32'd1);

        // 5: SPS=0 request while the clock is lost
        div_run = 1'b0;
        div_clk = 1'b0;
        wait_lost(n, en_cnt);
        check("t5_lost", {31'd0, bus.clk_lost}, 32'd1);
        bus.sps_req = 1'b1;
        bus.sps_val = 8'd0;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!bus.sps_ack && (n < 2));
        check("t5_ack_fast", {31'd0, bus.sps_ack}, 32'd1);
        check("t5_idx_forced", {24'd0, bus.sample_idx}, 32'd0);
        bus.sps_req = 1'b0;
        cyc();
        check("t5_ack_drop", {31'd0, bus.sps_ack}, 32'd0);
        cnt = 4'd7;
        div_run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_sample(n);
            if (i > 0) check("t5_spacing", n, 16);
            check("t5_idx", {24'd0, bus.sample_idx}, 32'd0);
            check("t5_sym", {31'd0, bus.symbol_en}, 32'd1);
        end

        // 6: reset while a change is pending
        bus.sps_req = 1'b1;
        bus.sps_val = 8'd3;
        cyc();
        cyc();
        check("t6_pend", {30'd0, bus.fsm_state}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_ack_rst", {31'd0, bus.sps_ack}, 32'd0);
        check("t6_sample_rst", {31'd0, bus.sample_en}, 32'd0);
        check("t6_symbol_rst", {31'd0, bus.symbol_en}, 32'd0);
        check("t6_state_rst", {30'd0, bus.fsm_state}, 32'd0);
        bus.sps_req = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_sample(n);
            check("t6_idx", {24'd0, bus.sample_idx}, i % 4);
            check("t6_sym", {31'd0, bus.symbol_en}, ((i % 4) == 0) ? 32'd1 : 32'd0);
            check("t6_ack", {31'd0, bus.sps_ack}, 32'd0);
        end
        check("no_stray_sym", stray, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
